// File: rtl/data_memory.sv
// data_memory: block-addressed main memory behind the data cache.
// Serves one block read or write at a time. mem_busywait is held for
// LATENCY cycles, counted from the request cycle. Read data, or the write
// commit, lands in the cycle that busywait drops.
// Optional macro DMEM_RESET_CLEAR_EN: reset also zeroes every array entry.

module data_memory #(
   parameter int unsigned LATENCY = 5
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [5:0]  mem_address,
   input  logic [31:0] mem_writedata,
   output logic [31:0] mem_readdata,
   output logic        mem_busywait
);

   localparam int unsigned ADDR_W = 6;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned DEPTH  = 64;

   typedef enum logic {
      IDLE,
      ACCESS
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    count;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   data_q;
   logic                op_write;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic                request_c;
   logic                commit_c;

   // Request detect, write-commit strobe and busywait.
   // Busywait is combinational so the requester sees it in its first
   // request cycle.
   always_comb begin
      request_c    = mem_read | mem_write;
      commit_c     = (state == ACCESS) && (count == '0) && op_write;
      mem_busywait = ((state == IDLE) && request_c) ||
                     ((state == ACCESS) && (count != '0));
   end

   // Control FSM: latch the request in IDLE, count down in ACCESS.
   // Read data is captured on the edge that enters the completion cycle, so
   // it is valid there and holds until the next read completes.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         count        <= '0;
         addr_q       <= '0;
         data_q       <= '0;
         op_write     <= 1'b0;
         mem_readdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (request_c) begin
                  addr_q   <= mem_address;
                  data_q   <= mem_writedata;
                  op_write <= mem_write;
                  count    <= CNT_W'(LATENCY - 1);
                  state    <= ACCESS;
                  if ((LATENCY == 1) && !mem_write) begin
                     mem_readdata <= mem[mem_address];
                  end
               end
            end
            ACCESS: begin
               if (count != '0) begin
                  count <= count - CNT_W'(1);
                  if ((count == CNT_W'(1)) && !op_write) begin
                     mem_readdata <= mem[addr_q];
                  end
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Block array: writes commit at the end of the completion cycle.
   // A reset in that cycle discards the write.
`ifdef DMEM_RESET_CLEAR_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[ADDR_W'(i)] <= '0;
         end
      end else if (commit_c) begin
         mem[addr_q] <= data_q;
      end
   end
`else
   always_ff @(posedge clock) begin
      if (!reset && commit_c) begin
         mem[addr_q] <= data_q;
      end
   end
`endif

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: scoreboard bench for data_memory.
// Expected read data is queued when a read is issued and compared when
// busywait drops. Busy-window length and read-data hold are also checked.

module tb_data_memory;

   localparam int unsigned LATENCY = 5;
   localparam int unsigned MAX_CYC = 40;

   logic        clock = 1'b0;
   logic        reset;
   logic        mem_read;
   logic        mem_write;
   logic [5:0]  mem_address;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;
   logic        mem_busywait;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] model [64];
   logic [31:0] exp_q [$];
   logic [31:0] last_read;

   always #5 clock = ~clock;

   data_memory #(.LATENCY(LATENCY)) dut (
      .clock         (clock),
      .reset         (reset),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_address   (mem_address),
      .mem_writedata (mem_writedata),
      .mem_readdata  (mem_readdata),
      .mem_busywait  (mem_busywait)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // One access. Inputs change at the negedge; outputs are sampled 1 ns later.
   // drop_after != 0 releases the request after that many busy cycles.
   // The request is left asserted during the completion cycle, as a real
   // requester would hold it.
   task automatic access(input string tag, input logic rd, input logic wr,
                         input logic [5:0] addr, input logic [31:0] data,
                         input int drop_after);
      int          busy;
      bit          done;
      logic [31:0] e;
      @(negedge clock);
      mem_read      = rd;
      mem_write     = wr;
      mem_address   = addr;
      mem_writedata = data;
      if (rd && !wr) exp_q.push_back(model[addr]);
      busy = 0;
      done = 1'b0;
      for (int c = 0; c < MAX_CYC && !done; c++) begin
         #1;
         if (!mem_busywait) begin
            done = 1'b1;
         end else begin
            busy++;
            @(negedge clock);
            if (drop_after != 0 && busy >= drop_after) begin
               mem_read  = 1'b0;
               mem_write = 1'b0;
            end
         end
      end
      check({tag, " busy"}, 32'(busy), 32'(LATENCY));
      if (!done) begin
         if (rd && !wr && exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (wr) begin
         model[addr] = data;
      end else if (rd) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, " data"}, mem_readdata, e);
            last_read = e;
         end else begin
            check({tag, " queue"}, 32'(exp_q.size()), 32'd1);
         end
      end
   endtask

   // Idle cycle: busywait low and read data still holding.
   task automatic idle(input string tag);
      @(negedge clock);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      #1;
      check({tag, " idle busy"}, 32'(mem_busywait), 32'd0);
      check({tag, " hold"}, mem_readdata, last_read);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0]  ra;
      logic [31:0] rdat;

      reset         = 1'b1;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_address   = '0;
      mem_writedata = '0;
      last_read     = '0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      #1;
      check("reset busy", 32'(mem_busywait), 32'd0);
      check("reset rdata", mem_readdata, 32'd0);

      // Write then read back.
      access("wr5", 1'b0, 1'b1, 6'd5, 32'hDEADBEEF, 0);
      idle("wr5");
      access("rd5", 1'b1, 1'b0, 6'd5, 32'h0, 0);
      idle("rd5");
      idle("rd5b");
      // A write must not disturb held read data.
      access("wr0", 1'b0, 1'b1, 6'd0, 32'h22222222, 0);
      idle("wr0");

      // Write-back then refill with no idle gap, then verify the write-back.
      access("wb63", 1'b0, 1'b1, 6'd63, 32'h11111111, 0);
      access("rf0", 1'b1, 1'b0, 6'd0, 32'h0, 0);
      access("rd63", 1'b1, 1'b0, 6'd63, 32'h0, 0);
      idle("b2b");

      // Requester drops the write after one cycle; it must still commit.
      access("drop9", 1'b0, 1'b1, 6'd9, 32'hA5A5A5A5, 1);
      idle("drop9");
      access("rd9a", 1'b1, 1'b0, 6'd9, 32'h0, 0);
      // Read and write together: the write wins.
      access("both9", 1'b1, 1'b1, 6'd9, 32'h0, 0);
      access("rd9b", 1'b1, 1'b0, 6'd9, 32'h0, 0);
      idle("prio");

      // Reset in busy cycle 3 of a write: no commit.
      access("pre12", 1'b0, 1'b1, 6'd12, 32'h12345678, 0);
      idle("pre12");
      @(negedge clock);
      mem_write     = 1'b1;
      mem_address   = 6'd12;
      mem_writedata = 32'hCAFEF00D;
      #1;
      check("rst c1 busy", 32'(mem_busywait), 32'd1);
      @(negedge clock);
      #1;
      check("rst c2 busy", 32'(mem_busywait), 32'd1);
      @(negedge clock);
      reset     = 1'b1;
      mem_write = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("rst busy", 32'(mem_busywait), 32'd0);
      check("rst rdata", mem_readdata, 32'd0);
      last_read = '0;
`ifdef DMEM_RESET_CLEAR_EN
      for (int i = 0; i < 64; i++) model[i] = '0;
`endif
      access("rd12", 1'b1, 1'b0, 6'd12, 32'h0, 0);
      idle("rd12");

      // Random write/read-back pairs, back to back.
      for (int k = 0; k < 6; k++) begin
         ra   = 6'($urandom_range(0, 63));
         rdat = $urandom;
         access("rnd wr", 1'b0, 1'b1, ra, rdat, 0);
         access("rnd rd", 1'b1, 1'b0, ra, 32'h0, 0);
      end
      idle("rnd");

      check("queue empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
